exc_commit_ctrl: RTL and testbench



---
 rtl/cp0_pkg.sv | 82 ++++++++
 rtl/exc_prio_enc.sv | 73 +++++++
 rtl/exc_commit_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_exc_commit_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// ----------------------------------------------------------------------------
// cp0_pkg
// Definitions shared by the CP0 block and the exception commit controller:
//   - exception codes (Cause.ExcCode values)
//   - CP0 register numbers
//   - bit positions inside mem_ex_vec
//   - the controller state encoding and the badvaddr source select
//   - per-flag lookup helpers used by the priority encoder
// Note: no ports (package only).
// ----------------------------------------------------------------------------
package cp0_pkg;

    // Exception codes
    localparam logic [4:0] EX_INT  = 5'h00;
    localparam logic [4:0] EX_ADEL = 5'h04;
    localparam logic [4:0] EX_ADES = 5'h05;
    localparam logic [4:0] EX_SYS  = 5'h08;
    localparam logic [4:0] EX_BP   = 5'h09;
    localparam logic [4:0] EX_RI   = 5'h0a;
    localparam logic [4:0] EX_OV   = 5'h0c;

    // CP0 register numbers (select 0)
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    // mem_ex_vec bit positions. The bit order is also the priority order:
    // the lowest set bit wins.
    localparam int EX_VEC_W    = 7;
    localparam int EXB_ADEL_IF = 0;
    localparam int EXB_RI      = 1;
    localparam int EXB_OV      = 2;
    localparam int EXB_SYS     = 3;
    localparam int EXB_BP      = 4;
    localparam int EXB_ADEL_LD = 5;
    localparam int EXB_ADES    = 6;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SIGNAL   = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_HOLD     = 2'd3
    } exc_ctrl_state_t;

    // Where BadVAddr comes from for the selected exception
    typedef enum logic [1:0] {
        BV_ZERO = 2'd0,
        BV_PC   = 2'd1,
        BV_DATA = 2'd2
    } badv_sel_t;

    // Exception code for one mem_ex_vec flag
    function automatic logic [4:0] ex_bit_code(input int idx);
        logic [4:0] code;
        case (idx)
            EXB_ADEL_IF: code = EX_ADEL;
            EXB_RI:      code = EX_RI;
            EXB_OV:      code = EX_OV;
            EXB_SYS:     code = EX_SYS;
            EXB_BP:      code = EX_BP;
            EXB_ADEL_LD: code = EX_ADEL;
            EXB_ADES:    code = EX_ADES;
            default:     code = EX_INT;
        endcase
        return code;
    endfunction

    // BadVAddr source for one mem_ex_vec flag
    function automatic badv_sel_t ex_bit_badv(input int idx);
        badv_sel_t sel;
        case (idx)
            EXB_ADEL_IF:           sel = BV_PC;
            EXB_ADEL_LD, EXB_ADES: sel = BV_DATA;
            default:               sel = BV_ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// ----------------------------------------------------------------------------
// exc_prio_enc
// Combinational priority encoder for the commit-stage exception sources.
// The priority order is: interrupt, then the mem_ex_vec flags (lowest bit
// first), then ERET. ERET is taken only when nothing else is pending.
//
// Ports:
//   int_pending  in   CP0 interrupt request
//   ex_vec       in   exception flags (see cp0_pkg EXB_* positions)
//   eret         in   instruction is ERET
//   hit          out  something to take (exception, interrupt or ERET)
//   is_eret      out  the winner is ERET (no exception/interrupt)
//   excode       out  exception code of the winner (0 for ERET)
//   badv_sel     out  BadVAddr source for the winner
//
// Configuration: EXC_CTRL_INT_EN -- when undefined, int_pending is ignored
// and EX_INT is never selected.
// ----------------------------------------------------------------------------
module exc_prio_enc
    import cp0_pkg::*;
(
    input  logic                int_pending,
    input  logic [EX_VEC_W-1:0] ex_vec,
    input  logic                eret,
    output logic                hit,
    output logic                is_eret,
    output logic [4:0]          excode,
    output badv_sel_t           badv_sel
);

    logic int_taken;

`ifdef EXC_CTRL_INT_EN
    assign int_taken = int_pending;
`else
    logic unused_int_pending;
    assign int_taken          = 1'b0;
    assign unused_int_pending = int_pending;
`endif

    // lower_any[i]: some higher-priority source than flag i is active.
    // lower_any[EX_VEC_W] therefore means "any exception or interrupt".
    logic [EX_VEC_W:0]   lower_any;
    logic [EX_VEC_W-1:0] grant;

    assign lower_any[0] = int_taken;

    genvar gi;
    generate
        for (gi = 0; gi < EX_VEC_W; gi++) begin : g_grant
            assign grant[gi]       = ex_vec[gi] & ~lower_any[gi];
            assign lower_any[gi+1] = lower_any[gi] | ex_vec[gi];
        end
    endgenerate

    // At most one grant bit is set, so OR-ing the per-flag codes is a mux.
    // With no grant (interrupt, ERET or nothing) the defaults apply: EX_INT
    // and a zero BadVAddr.
    always_comb begin
        excode   = EX_INT;
        badv_sel = BV_ZERO;
        for (int i = 0; i < EX_VEC_W; i++) begin
            if (grant[i]) begin
                excode   = excode | ex_bit_code(i);
                badv_sel = ex_bit_badv(i);
            end
        end
    end

    assign hit     = lower_any[EX_VEC_W] | eret;
    assign is_eret = eret & ~lower_any[EX_VEC_W];

endmodule

// File: rtl/exc_commit_ctrl.sv
// ----------------------------------------------------------------------------
// exc_commit_ctrl
// Exception/interrupt commit controller sitting between the MEM/commit stage
// and CP0. When the commit instruction carries an exception, sees an
// interrupt, or is an ERET, the controller:
//   N    kills the instruction's side effects (commit_kill, combinational)
//   N+1  pulses the CP0 exception port (cp0_ex or eret_flush), raises flush,
//        captures the CP0 target (cp0_int_pc) as the redirect PC
//   N+2  presents redirect_valid/redirect_pc until redirect_ready
//   then holds flush FLUSH_HOLD more cycles before returning to IDLE.
// Events arriving while busy are ignored (the pipeline is being flushed).
//
// Parameters:
//   FLUSH_HOLD      extra flush cycles after the redirect handshake (0..15)
// Ports:
//   clk, resetn     clock, synchronous active-low reset
//   mem_*           commit-stage instruction info
//   int_pending     CP0 interrupt request
//   cp0_int_pc      CP0 exception vector / EPC, valid during cp0_ex/eret_flush
//   commit_kill     suppress side effects of the commit instruction
//   cp0_ex, cp0_bd, eret_flush, cp0_excode, cp0_pc, cp0_badvaddr
//                   CP0 exception port, nonzero only in SIGNAL
//   flush           whole-pipeline flush
//   redirect_*      fetch redirect valid/ready handshake and target
//   busy            controller is not IDLE
//
// Configuration macro: EXC_CTRL_INT_EN (interrupt arbitration enable).
// ----------------------------------------------------------------------------
module exc_commit_ctrl
    import cp0_pkg::*;
#(
    parameter int unsigned FLUSH_HOLD = 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                mem_valid,
    input  logic [31:0]         mem_pc,
    input  logic                mem_bd,
    input  logic [EX_VEC_W-1:0] mem_ex_vec,
    input  logic [31:0]         mem_data_addr,
    input  logic                mem_eret,
    input  logic                int_pending,
    input  logic [31:0]         cp0_int_pc,
    output logic                commit_kill,
    output logic                cp0_ex,
    output logic                cp0_bd,
    output logic                eret_flush,
    output logic [4:0]          cp0_excode,
    output logic [31:0]         cp0_pc,
    output logic [31:0]         cp0_badvaddr,
    output logic                flush,
    output logic                redirect_valid,
    output logic [31:0]         redirect_pc,
    input  logic                redirect_ready,
    output logic                busy
);

    // Last HOLD count value; only meaningful when FLUSH_HOLD > 0.
    localparam logic [3:0] HOLD_LAST = 4'(FLUSH_HOLD - 1);

    // ------------------------------------------------------------------
    // Priority selection
    // ------------------------------------------------------------------
    logic       enc_hit;
    logic       enc_is_eret;
    logic [4:0] enc_excode;
    badv_sel_t  enc_badv_sel;

    exc_prio_enc u_prio_enc (
        .int_pending (int_pending),
        .ex_vec      (mem_ex_vec),
        .eret        (mem_eret),
        .hit         (enc_hit),
        .is_eret     (enc_is_eret),
        .excode      (enc_excode),
        .badv_sel    (enc_badv_sel)
    );

    logic [31:0] badv_next;

    always_comb begin
        badv_next = 32'h0;
        case (enc_badv_sel)
            BV_PC:   badv_next = mem_pc;
            BV_DATA: badv_next = mem_data_addr;
            default: badv_next = 32'h0;
        endcase
    end

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    exc_ctrl_state_t state_reg;
    logic [3:0]      hold_cnt_reg;
    logic            cp0_ex_reg;
    logic            cp0_bd_reg;
    logic            eret_flush_reg;
    logic [4:0]      cp0_excode_reg;
    logic [31:0]     cp0_pc_reg;
    logic [31:0]     cp0_badvaddr_reg;
    logic            flush_reg;
    logic            redirect_valid_reg;
    logic [31:0]     redirect_pc_reg;

    logic evt_hit;
    assign evt_hit = mem_valid & enc_hit;

    // The CP0 port registers double as the latch for the selected
    // exception: loaded on the IDLE event, visible for exactly the SIGNAL
    // cycle, cleared on the way out of SIGNAL.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg          <= ST_IDLE;
            hold_cnt_reg       <= 4'd0;
            cp0_ex_reg         <= 1'b0;
            cp0_bd_reg         <= 1'b0;
            eret_flush_reg     <= 1'b0;
            cp0_excode_reg     <= 5'd0;
            cp0_pc_reg         <= 32'h0;
            cp0_badvaddr_reg   <= 32'h0;
            flush_reg          <= 1'b0;
            redirect_valid_reg <= 1'b0;
            redirect_pc_reg    <= 32'h0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (evt_hit) begin
                        state_reg      <= ST_SIGNAL;
                        flush_reg      <= 1'b1;
                        cp0_ex_reg     <= ~enc_is_eret;
                        eret_flush_reg <= enc_is_eret;
                        // ERET leaves the exception fields at zero.
                        if (!enc_is_eret) begin
                            cp0_bd_reg       <= mem_bd;
                            cp0_excode_reg   <= enc_excode;
                            cp0_pc_reg       <= mem_pc;
                            cp0_badvaddr_reg <= badv_next;
                        end
                    end
                end

                ST_SIGNAL: begin
                    state_reg          <= ST_REDIRECT;
                    cp0_ex_reg         <= 1'b0;
                    cp0_bd_reg         <= 1'b0;
                    eret_flush_reg     <= 1'b0;
                    cp0_excode_reg     <= 5'd0;
                    cp0_pc_reg         <= 32'h0;
                    cp0_badvaddr_reg   <= 32'h0;
                    // CP0 presents the vector/EPC while the port pulse is up.
                    redirect_pc_reg    <= cp0_int_pc;
                    redirect_valid_reg <= 1'b1;
                end

                ST_REDIRECT: begin
                    if (redirect_ready) begin
                        redirect_valid_reg <= 1'b0;
                        if (FLUSH_HOLD > 0) begin
                            state_reg    <= ST_HOLD;
                            hold_cnt_reg <= 4'd0;
                        end else begin
                            state_reg <= ST_IDLE;
                            flush_reg <= 1'b0;
                        end
                    end
                end

                ST_HOLD: begin
                    if (hold_cnt_reg == HOLD_LAST) begin
                        state_reg    <= ST_IDLE;
                        hold_cnt_reg <= 4'd0;
                        flush_reg    <= 1'b0;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 4'd1;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                    flush_reg <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // commit_kill is the only combinational output; gate it with reset so
    // every output is quiet while resetn is low.
    assign commit_kill    = resetn & (state_reg == ST_IDLE) & evt_hit;
    assign busy           = (state_reg != ST_IDLE);
    assign cp0_ex         = cp0_ex_reg;
    assign cp0_bd         = cp0_bd_reg;
    assign eret_flush     = eret_flush_reg;
    assign cp0_excode     = cp0_excode_reg;
    assign cp0_pc         = cp0_pc_reg;
    assign cp0_badvaddr   = cp0_badvaddr_reg;
    assign flush          = flush_reg;
    assign redirect_valid = redirect_valid_reg;
    assign redirect_pc    = redirect_pc_reg;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// ----------------------------------------------------------------------------
// tb_exc_commit_ctrl
// Self-checking bench for exc_commit_ctrl (FLUSH_HOLD = 1). A table of
// directed commit vectors covers the priority/badvaddr selection and the
// basic event timing; hand-written sequences cover the stalled ERET
// redirect, events while busy, and reset in the middle of a redirect.
// Expected values for interrupt vectors follow EXC_CTRL_INT_EN.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_exc_commit_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        mem_bd;
    logic [6:0]  mem_ex_vec;
    logic [31:0] mem_data_addr;
    logic        mem_eret;
    logic        int_pending;
    logic [31:0] cp0_int_pc;
    logic        commit_kill;
    logic        cp0_ex;
    logic        cp0_bd;
    logic        eret_flush;
    logic [4:0]  cp0_excode;
    logic [31:0] cp0_pc;
    logic [31:0] cp0_badvaddr;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        busy;

    always #5 clk = ~clk;

    exc_commit_ctrl #(.FLUSH_HOLD(1)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .mem_valid      (mem_valid),
        .mem_pc         (mem_pc),
        .mem_bd         (mem_bd),
        .mem_ex_vec     (mem_ex_vec),
        .mem_data_addr  (mem_data_addr),
        .mem_eret       (mem_eret),
        .int_pending    (int_pending),
        .cp0_int_pc     (cp0_int_pc),
        .commit_kill    (commit_kill),
        .cp0_ex         (cp0_ex),
        .cp0_bd         (cp0_bd),
        .eret_flush     (eret_flush),
        .cp0_excode     (cp0_excode),
        .cp0_pc         (cp0_pc),
        .cp0_badvaddr   (cp0_badvaddr),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .busy           (busy)
    );

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic        bd;
        logic [6:0]  ex;
        logic [31:0] addr;
        logic        eret;
        logic        intp;
        logic [31:0] tgt;
        logic        hit;
        logic        is_ex;
        logic [4:0]  code;
        logic [31:0] badv;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mem_valid     = 1'b0;
        mem_pc        = 32'h0;
        mem_bd        = 1'b0;
        mem_ex_vec    = 7'h0;
        mem_data_addr = 32'h0;
        mem_eret      = 1'b0;
        int_pending   = 1'b0;
    endtask

    function automatic vec_t mk(input logic valid, input logic [31:0] pc, input logic bd,
                                input logic [6:0] ex, input logic [31:0] addr,
                                input logic eret, input logic intp, input logic hit,
                                input logic is_ex, input logic [4:0] code,
                                input logic [31:0] badv);
        vec_t v;
        v.valid = valid; v.pc = pc; v.bd = bd; v.ex = ex; v.addr = addr;
        v.eret = eret; v.intp = intp; v.hit = hit; v.is_ex = is_ex;
        v.code = code; v.badv = badv;
        v.tgt = is_ex ? 32'hBFC00380 : 32'h80000040;
        return v;
    endfunction

    // Applies one vector from IDLE, runs the full sequence with
    // redirect_ready high, and checks every stage of it.
    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        mem_valid      = v.valid;
        mem_pc         = v.pc;
        mem_bd         = v.bd;
        mem_ex_vec     = v.ex;
        mem_data_addr  = v.addr;
        mem_eret       = v.eret;
        int_pending    = v.intp;
        cp0_int_pc     = v.tgt;
        redirect_ready = 1'b1;
        #1;
        chk($sformatf("v%0d commit_kill", idx), 32'(commit_kill), 32'(v.hit));
        tick();
        clear_inputs();
        if (v.hit) begin
            chk($sformatf("v%0d cp0_ex", idx),       32'(cp0_ex),     32'(v.is_ex));
            chk($sformatf("v%0d eret_flush", idx),   32'(eret_flush), 32'(!v.is_ex));
            chk($sformatf("v%0d cp0_excode", idx),   32'(cp0_excode), 32'(v.code));
            chk($sformatf("v%0d cp0_pc", idx),       cp0_pc,          v.is_ex ? v.pc : 32'h0);
            chk($sformatf("v%0d cp0_bd", idx),       32'(cp0_bd),     32'(v.is_ex & v.bd));
            chk($sformatf("v%0d cp0_badvaddr", idx), cp0_badvaddr,    v.badv);
            chk($sformatf("v%0d flush_n1", idx),     32'(flush),      32'h1);
            tick();
            chk($sformatf("v%0d redirect_valid", idx), 32'(redirect_valid), 32'h1);
            chk($sformatf("v%0d redirect_pc", idx),    redirect_pc,         v.tgt);
            chk($sformatf("v%0d cp0_ex_n2", idx),      32'(cp0_ex | eret_flush), 32'h0);
            cyc = 0;
            while (busy && cyc < 20) begin
                tick();
                cyc++;
            end
            // REDIRECT at N+2 accepted at once, HOLD at N+3, IDLE at N+4
            chk($sformatf("v%0d cycles_to_idle", idx), 32'(cyc),   32'd2);
            chk($sformatf("v%0d flush_idle", idx),     32'(flush), 32'h0);
        end else begin
            chk($sformatf("v%0d busy_nohit", idx),   32'(busy),   32'h0);
            chk($sformatf("v%0d cp0_ex_nohit", idx), 32'(cp0_ex), 32'h0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " commit_kill"},    32'(commit_kill),    32'h0);
        chk({tag, " cp0_ex"},         32'(cp0_ex),         32'h0);
        chk({tag, " cp0_bd"},         32'(cp0_bd),         32'h0);
        chk({tag, " eret_flush"},     32'(eret_flush),     32'h0);
        chk({tag, " cp0_excode"},     32'(cp0_excode),     32'h0);
        chk({tag, " cp0_pc"},         cp0_pc,              32'h0);
        chk({tag, " cp0_badvaddr"},   cp0_badvaddr,        32'h0);
        chk({tag, " flush"},          32'(flush),          32'h0);
        chk({tag, " redirect_valid"}, 32'(redirect_valid), 32'h0);
        chk({tag, " redirect_pc"},    redirect_pc,         32'h0);
        chk({tag, " busy"},           32'(busy),           32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rv_cnt;
        int ef_cnt;

        //   valid pc            bd ex     addr          eret int hit ex code   badv
        vecs[0]  = mk(1, 32'hBFC00100, 0, 7'h08, 32'h0,        0, 0, 1, 1, 5'h08, 32'h0);
        vecs[1]  = mk(1, 32'h80000010, 0, 7'h44, 32'h80001003, 0, 0, 1, 1, 5'h0c, 32'h0);
        vecs[2]  = mk(1, 32'h80000014, 0, 7'h40, 32'h80001003, 0, 0, 1, 1, 5'h05, 32'h80001003);
        vecs[3]  = mk(1, 32'h80000003, 0, 7'h01, 32'h0,        0, 0, 1, 1, 5'h04, 32'h80000003);
        vecs[4]  = mk(1, 32'h80000200, 0, 7'h20, 32'h80000011, 0, 0, 1, 1, 5'h04, 32'h80000011);
        vecs[5]  = mk(1, 32'h80000204, 1, 7'h10, 32'h0,        0, 0, 1, 1, 5'h09, 32'h0);
        vecs[6]  = mk(1, 32'h80000208, 0, 7'h0A, 32'h0,        0, 0, 1, 1, 5'h0a, 32'h0);
        vecs[7]  = mk(1, 32'h80000101, 0, 7'h41, 32'h80002002, 0, 0, 1, 1, 5'h04, 32'h80000101);
`ifdef EXC_CTRL_INT_EN
        vecs[8]  = mk(1, 32'h800000A4, 1, 7'h02, 32'h0,        0, 1, 1, 1, 5'h00, 32'h0);
        vecs[9]  = mk(1, 32'h80000300, 0, 7'h00, 32'h0,        0, 1, 1, 1, 5'h00, 32'h0);
`else
        vecs[8]  = mk(1, 32'h800000A4, 1, 7'h02, 32'h0,        0, 1, 1, 1, 5'h0a, 32'h0);
        vecs[9]  = mk(1, 32'h80000300, 0, 7'h00, 32'h0,        0, 1, 0, 1, 5'h00, 32'h0);
`endif
        vecs[10] = mk(0, 32'h80000304, 0, 7'h00, 32'h0,        0, 1, 0, 1, 5'h00, 32'h0);
        vecs[11] = mk(1, 32'h80000308, 0, 7'h10, 32'h0,        1, 0, 1, 1, 5'h09, 32'h0);
        vecs[12] = mk(1, 32'h8000030C, 0, 7'h00, 32'h0,        1, 0, 1, 0, 5'h00, 32'h0);
        vecs[13] = mk(1, 32'h80000310, 0, 7'h00, 32'h0,        0, 0, 0, 1, 5'h00, 32'h0);
        vecs[14] = mk(0, 32'h80000314, 0, 7'h08, 32'h0,        0, 0, 0, 1, 5'h00, 32'h0);

        // Reset
        resetn         = 1'b0;
        redirect_ready = 1'b0;
        cp0_int_pc     = 32'h0;
        clear_inputs();
        repeat (3) tick();
        chk_all_zero("reset");
        resetn = 1'b1;
        tick();

        // Table-driven vectors
        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], i);
            $display("vector %0d done: pc=%h ex=%h eret=%0d int=%0d", i, vecs[i].pc,
                     vecs[i].ex, vecs[i].eret, vecs[i].intp);
        end

        // ERET with redirect_ready low for 5 cycles, SYS offered while busy
        rv_cnt = 0;
        ef_cnt = 0;
        mem_valid      = 1'b1;
        mem_eret       = 1'b1;
        mem_pc         = 32'h80000500;
        cp0_int_pc     = 32'h80000040;
        redirect_ready = 1'b0;
        #1;
        chk("eret commit_kill", 32'(commit_kill), 32'h1);
        tick();
        clear_inputs();
        ef_cnt += int'(eret_flush);
        chk("eret cp0_ex", 32'(cp0_ex), 32'h0);
        chk("eret flush_n1", 32'(flush), 32'h1);
        tick();
        cp0_int_pc = 32'hDEADBEEF;
        mem_valid  = 1'b1;
        mem_ex_vec = 7'h08;
        mem_pc     = 32'h80000600;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) redirect_ready = 1'b1;
            #1;
            chk($sformatf("eret busy commit_kill c%0d", i), 32'(commit_kill), 32'h0);
            chk($sformatf("eret redirect_pc c%0d", i), redirect_pc, 32'h80000040);
            chk($sformatf("eret flush c%0d", i), 32'(flush), 32'h1);
            rv_cnt += int'(redirect_valid);
            ef_cnt += int'(eret_flush);
            tick();
        end
        clear_inputs();
        chk("eret hold busy", 32'(busy), 32'h1);
        chk("eret hold flush", 32'(flush), 32'h1);
        chk("eret hold redirect_valid", 32'(redirect_valid), 32'h0);
        chk("eret hold cp0_ex", 32'(cp0_ex), 32'h0);
        ef_cnt += int'(eret_flush);
        tick();
        chk("eret idle busy", 32'(busy), 32'h0);
        chk("eret idle flush", 32'(flush), 32'h0);
        chk("eret idle cp0_ex", 32'(cp0_ex), 32'h0);
        chk("eret redirect_valid cycles", 32'(rv_cnt), 32'd6);
        chk("eret_flush pulses", 32'(ef_cnt), 32'd1);
        $display("eret stall sequence done: redirect_valid cycles=%0d eret pulses=%0d",
                 rv_cnt, ef_cnt);

        // Reset during REDIRECT, then a normal SYS
        mem_valid      = 1'b1;
        mem_ex_vec     = 7'h08;
        mem_pc         = 32'hBFC00100;
        cp0_int_pc     = 32'hBFC00380;
        redirect_ready = 1'b0;
        tick();
        clear_inputs();
        tick();
        chk("mid-reset in redirect", 32'(redirect_valid), 32'h1);
        resetn = 1'b0;
        tick();
        chk_all_zero("mid-reset");
        resetn = 1'b1;
        run_vec(vecs[0], 100);
        $display("reset during redirect sequence done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
